// File: rtl/mem_axi_master.sv
`default_nettype none
// ============================================================================
// mem_axi_master: turns single MMU request pulses into AXI4-Lite transfers.
// Optional MEM_AXI_MASTER_BUSERR_EN reports rresp/bresp errors. Rev 1.0
// ============================================================================
module mem_axi_master #(
  parameter logic [2:0] PROT = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request_enable,
  input  logic        req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        response_enable,
  output logic [31:0] resp_data,
  output logic        bus_error,
  output logic        busy,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        response_enable_q, response_enable_d;
  logic        busy_q, busy_d;
  logic        bus_error_q, bus_error_d;
  logic        aw_done, w_done;
  logic        rd_err, wr_err;

`ifdef MEM_AXI_MASTER_BUSERR_EN
  assign rd_err = (rresp != 2'b00);
  assign wr_err = (bresp != 2'b00);
`else
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};
  assign rd_err      = 1'b0;
  assign wr_err      = 1'b0;
`endif

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    wstrb_d           = wstrb_q;
    resp_data_d       = resp_data_q;
    arvalid_d         = arvalid_q;
    rready_d          = rready_q;
    awvalid_d         = awvalid_q;
    wvalid_d          = wvalid_q;
    bready_d          = bready_q;
    busy_d            = busy_q;
    response_enable_d = 1'b0;
    bus_error_d       = 1'b0;
    // A channel counts as done once its valid has already dropped or handshakes now.
    aw_done           = !awvalid_q || awready;
    w_done            = !wvalid_q || wready;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (request_enable) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          busy_d  = 1'b1;
          if (req_mode) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          rready_d          = 1'b0;
          response_enable_d = 1'b1;
          bus_error_d       = rd_err;
          resp_data_d       = rd_err ? 32'd0 : rdata;
          state_d           = DONE;
        end
      end
      WR_REQ: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          bready_d          = 1'b0;
          response_enable_d = 1'b1;
          bus_error_d       = wr_err;
          resp_data_d       = 32'd0;
          state_d           = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      addr_q            <= 32'd0;
      wdata_q           <= 32'd0;
      wstrb_q           <= 4'd0;
      resp_data_q       <= 32'd0;
      arvalid_q         <= 1'b0;
      rready_q          <= 1'b0;
      awvalid_q         <= 1'b0;
      wvalid_q          <= 1'b0;
      bready_q          <= 1'b0;
      response_enable_q <= 1'b0;
      busy_q            <= 1'b0;
      bus_error_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      wstrb_q           <= wstrb_d;
      resp_data_q       <= resp_data_d;
      arvalid_q         <= arvalid_d;
      rready_q          <= rready_d;
      awvalid_q         <= awvalid_d;
      wvalid_q          <= wvalid_d;
      bready_q          <= bready_d;
      response_enable_q <= response_enable_d;
      busy_q            <= busy_d;
      bus_error_q       <= bus_error_d;
    end
  end

  assign response_enable = response_enable_q;
  assign resp_data       = resp_data_q;
  assign bus_error       = bus_error_q;
  assign busy            = busy_q;
  assign araddr          = addr_q;
  assign arprot          = PROT;
  assign arvalid         = arvalid_q;
  assign rready          = rready_q;
  assign awaddr          = addr_q;
  assign awprot          = PROT;
  assign awvalid         = awvalid_q;
  assign wdata           = wdata_q;
  assign wstrb           = wstrb_q;
  assign wvalid          = wvalid_q;
  assign bready          = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_axi_master.sv
`default_nettype none
// ============================================================================
// tb_mem_axi_master: directed self-checking bench for mem_axi_master.
// Rev 1.0
// ============================================================================
module tb_mem_axi_master;

`ifdef MEM_AXI_MASTER_BUSERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        request_enable, req_mode;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable, bus_error, busy;
  logic [31:0] resp_data;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arprot, awprot;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;

  mem_axi_master #(.PROT(3'b010)) dut (
    .clk(clk), .rst(rst),
    .request_enable(request_enable), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .response_enable(response_enable), .resp_data(resp_data),
    .bus_error(bus_error), .busy(busy),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rr,
                         input int ar_wait, input string tag);
    logic err;
    err = ERR_EN && (rr != 2'b00);
    request_enable = 1'b1; req_mode = 1'b0; req_addr = a;
    tick;
    request_enable = 1'b0;
    check_eq({tag, ".busy"}, busy, 1);
    check_eq({tag, ".arvalid"}, arvalid, 1);
    check_eq({tag, ".araddr"}, araddr, a);
    check_eq({tag, ".arprot"}, arprot, 3'b010);
    for (int c = 0; c < ar_wait; c++) begin
      tick;
      check_eq({tag, ".arhold"}, arvalid, 1);
    end
    arready = 1'b1;
    tick;
    arready = 1'b0;
    check_eq({tag, ".arvalid_drop"}, arvalid, 0);
    check_eq({tag, ".rready"}, rready, 1);
    rvalid = 1'b1; rdata = d; rresp = rr;
    tick;
    rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
    check_eq({tag, ".resp_en"}, response_enable, 1);
    check_eq({tag, ".busy_done"}, busy, 1);
    check_eq({tag, ".resp_data"}, resp_data, err ? 32'd0 : d);
    check_eq({tag, ".bus_error"}, bus_error, err);
    tick;
    check_eq({tag, ".resp_en_off"}, response_enable, 0);
    check_eq({tag, ".busy_off"}, busy, 0);
    check_eq({tag, ".resp_hold"}, resp_data, err ? 32'd0 : d);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_wait, input int w_wait, input logic [1:0] br,
                          input string tag);
    int last;
    last = (aw_wait > w_wait) ? aw_wait : w_wait;
    request_enable = 1'b1; req_mode = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s;
    tick;
    request_enable = 1'b0;
    check_eq({tag, ".awvalid"}, awvalid, 1);
    check_eq({tag, ".wvalid"}, wvalid, 1);
    check_eq({tag, ".awaddr"}, awaddr, a);
    check_eq({tag, ".wdata"}, wdata, d);
    check_eq({tag, ".wstrb"}, wstrb, s);
    for (int c = 0; c <= last; c++) begin
      awready = (c == aw_wait);
      wready  = (c == w_wait);
      tick;
      check_eq({tag, ".awv_cyc"}, awvalid, (c < aw_wait));
      check_eq({tag, ".wv_cyc"}, wvalid, (c < w_wait));
    end
    awready = 1'b0; wready = 1'b0;
    check_eq({tag, ".bready"}, bready, 1);
    bvalid = 1'b1; bresp = br;
    tick;
    bvalid = 1'b0; bresp = 2'b00;
    check_eq({tag, ".resp_en"}, response_enable, 1);
    check_eq({tag, ".resp_data"}, resp_data, 0);
    check_eq({tag, ".bus_error"}, bus_error, ERR_EN && (br != 2'b00));
    tick;
    check_eq({tag, ".resp_en_off"}, response_enable, 0);
    check_eq({tag, ".busy_off"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    rst = 1'b1; request_enable = 1'b0; req_mode = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    tick; tick;
    // Request raised together with reset must be dropped.
    request_enable = 1'b1;
    tick;
    request_enable = 1'b0; rst = 1'b0;
    check_eq("rst.busy", busy, 0);
    check_eq("rst.arvalid", arvalid, 0);
    check_eq("rst.resp_en", response_enable, 0);
    check_eq("rst.resp_data", resp_data, 0);
    check_eq("rst.bus_error", bus_error, 0);
    tick;
    check_eq("rst_req.busy", busy, 0);
    check_eq("rst_req.arvalid", arvalid, 0);

    do_read(32'h1000_0004, 32'hDEAD_BEEF, 2'b00, 0, "rd0");
    do_read(32'h2000_0008, 32'h0BAD_F00D, 2'b00, 2, "rd_stall");
    do_write(32'h8000_0010, 32'h1234_5678, 4'b0011, 2, 0, 2'b00, "wr_aw3");
    do_write(32'h8000_0020, 32'hA5A5_5A5A, 4'b1111, 0, 1, 2'b00, "wr_wlate");

    // Second request during RD_DATA is ignored.
    request_enable = 1'b1; req_mode = 1'b0; req_addr = 32'h3000_0000;
    tick;
    request_enable = 1'b0; arready = 1'b1;
    tick;
    arready = 1'b0;
    check_eq("dup.rready", rready, 1);
    request_enable = 1'b1; req_addr = 32'h4000_0000;
    tick;
    request_enable = 1'b0;
    check_eq("dup.no_ar", arvalid, 0);
    check_eq("dup.rready_hold", rready, 1);
    check_eq("dup.araddr", araddr, 32'h3000_0000);
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    tick;
    rvalid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      if (response_enable) pulses++;
      if (arvalid) pulses += 10;
      tick;
    end
    check_eq("dup.pulses", pulses, 1);
    check_eq("dup.resp_data", resp_data, 32'hCAFE_F00D);

    // Reset while waiting for B, then a late bvalid.
    request_enable = 1'b1; req_mode = 1'b1; req_addr = 32'h5000_0000; req_wdata = 32'h1;
    tick;
    request_enable = 1'b0; awready = 1'b1; wready = 1'b1;
    tick;
    awready = 1'b0; wready = 1'b0;
    check_eq("rstwr.bready", bready, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_eq("rstwr.bready_clr", bready, 0);
    check_eq("rstwr.busy", busy, 0);
    check_eq("rstwr.resp_data", resp_data, 0);
    check_eq("rstwr.awaddr", awaddr, 0);
    bvalid = 1'b1;
    tick;
    bvalid = 1'b0;
    check_eq("rstwr.no_resp", response_enable, 0);
    check_eq("rstwr.busy2", busy, 0);
    tick;
    check_eq("rstwr.no_resp2", response_enable, 0);
    do_read(32'h6000_0000, 32'h7777_1111, 2'b00, 0, "rd_after_rst");

    do_read(32'h7000_0000, 32'h55AA_55AA, 2'b10, 0, "rd_err");
    do_write(32'h9000_0000, 32'h0000_00FF, 4'b0001, 0, 0, 2'b11, "wr_err");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_axi_master.md
MEM_AXI_MASTER -- requirements
Module: mem_axi_master

Interface
REQ-001 Parameter PROT, default 3'b000, SHALL be the constant value driven on arprot and awprot.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 request_enable  in  1  single-cycle request pulse from the MMU.
REQ-005 req_mode  in  1  0 = read, 1 = write.
REQ-006 req_addr / req_wdata  in  32 / 32  byte address, write data.
REQ-007 req_wstrb  in  4  write byte enables.
REQ-008 response_enable  out  1  single-cycle completion pulse.
REQ-009 resp_data  out  32  read data; 0 for writes.
REQ-010 bus_error  out  1  valid with response_enable; see REQ-031.
REQ-011 busy  out  1  high from request capture until the response_enable cycle, inclusive.
REQ-012 AXI4-Lite master: araddr 32, arprot 3, arvalid, arready, rdata 32, rresp 2, rvalid, rready, awaddr 32, awprot 3, awvalid, awready, wdata 32, wstrb 4, wvalid, wready, bresp 2, bvalid, bready, with standard AXI directions.

Function
REQ-013 States SHALL be IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
REQ-014 In IDLE, request_enable=1 SHALL latch addr/wdata/wstrb/mode, go to RD_ADDR (mode 0) or WR_REQ (mode 1), and set busy the next cycle.
REQ-015 request_enable while busy=1 SHALL be ignored, with no state or output change.
REQ-016 RD_ADDR: arvalid=1 and araddr=latched addr, stable until arready; on arvalid&arready go to RD_DATA with arvalid=0 next cycle.
REQ-017 RD_DATA: rready=1; on rvalid&rready latch rdata into resp_data and go to DONE.
REQ-018 WR_REQ: awvalid and wvalid SHALL rise in the same cycle; each drops independently the cycle after its own handshake; leave for WR_RESP once both have handshaken, in the same or different cycles.
REQ-019 WR_RESP: bready=1; on bvalid&bready go to DONE, with resp_data=0.
REQ-020 DONE: response_enable=1 for exactly one cycle, busy=1 in that cycle, then IDLE.
REQ-021 Minimum latency, slave ready every cycle: request pulse in cycle N, response_enable in cycle N+3 for a read and N+3 for a write.
REQ-022 valid signals SHALL never depend combinationally on ready; payloads SHALL stay stable while valid=1 and ready=0.
REQ-023 arready, awready or wready high before the matching valid SHALL cause no handshake.
REQ-024 resp_data SHALL hold its value between responses.
REQ-025 Unbounded slave stalls SHALL be tolerated with no timeout.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and clear all valid/ready outputs, response_enable, bus_error, busy and resp_data to 0.
REQ-027 Reset mid-transaction SHALL abandon the transfer with no response pulse; an in-flight slave response after reset SHALL be ignored.
REQ-028 request_enable in the same cycle as rst=1 SHALL be dropped.

Configuration
REQ-029 Macro MEM_AXI_MASTER_BUSERR_EN SHALL control error reporting.
REQ-030 Undefined: bus_error is tied 0 and rresp/bresp are ignored.
REQ-031 Defined: bus_error=1 with response_enable when rresp/bresp != 2'b00; a failed read SHALL return resp_data=0.

Verification
REQ-032 Read, slave always ready, rdata=32'hDEADBEEF -> araddr=req_addr in cycle N+1, response_enable in N+3, resp_data=32'hDEADBEEF, bus_error=0.
REQ-033 Write addr 32'h8000_0010, wdata 32'h1234_5678, wstrb 4'b0011; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles, a single response_enable, resp_data=0.
REQ-034 Second request_enable while in RD_DATA -> no second AR transfer, exactly one response_enable.
REQ-035 rst pulsed while in WR_RESP, then bvalid=1 -> no response_enable, all outputs 0, next read completes normally.
REQ-036 MEM_AXI_MASTER_BUSERR_EN defined, rresp=2'b10 -> bus_error=1, resp_data=0; macro undefined -> bus_error=0, resp_data=rdata.
